// File: rtl/accel_sequencer_if.sv
// SPI master request/response bundle shared between the accelerometer
// sequencer (master side) and the byte-level SPI engine (slave side).
`timescale 1ns/1ps
interface accel_sequencer_if;
    logic        spi_enable;
    logic        spi_rw;
    logic [5:0]  spi_address;
    logic [7:0]  spi_value;
    logic        spi_sync;
    logic [55:0] spi_buffer;

    modport master (
        output spi_enable,
        output spi_rw,
        output spi_address,
        output spi_value,
        input  spi_sync,
        input  spi_buffer
    );

    modport slave (
        input  spi_enable,
        input  spi_rw,
        input  spi_address,
        input  spi_value,
        output spi_sync,
        output spi_buffer
    );
endinterface

// File: rtl/accel_sequencer.sv
// Configures a 3-axis accelerometer over a shared SPI master, then reads
// X/Y/Z at a fixed sample rate, queuing at most one tick while a read runs.
`timescale 1ns/1ps
module accel_sequencer #(
    parameter int unsigned SAMPLE_DIV      = 120000,
    parameter logic [7:0]  BW_RATE_VAL     = 8'h0A,
    parameter logic [7:0]  DATA_FORMAT_VAL = 8'h0B,
    parameter logic [7:0]  POWER_CTL_VAL   = 8'h08
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    accel_sequencer_if.master spi,
    output logic [15:0]       x,
    output logic [15:0]       y,
    output logic [15:0]       z,
    output logic              sample_valid,
    output logic              config_done,
    output logic              overrun
);
    localparam int unsigned      CNT_W     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [5:0]       DATA_ADDR = 6'h32;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        CFG_ISSUE   = 3'd1,
        CFG_RELEASE = 3'd2,
        WAIT_TICK   = 3'd3,
        RD_ISSUE    = 3'd4,
        RD_RELEASE  = 3'd5
    } state_t;

    state_t           state_r;
    logic             spi_enable_r;
    logic             spi_rw_r;
    logic [5:0]       spi_address_r;
    logic [7:0]       spi_value_r;
    logic [15:0]      x_r;
    logic [15:0]      y_r;
    logic [15:0]      z_r;
    logic             sample_valid_r;
    logic             config_done_r;
    logic             overrun_r;
    logic             pending_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       cfg_idx_r;
    logic             tick_s;
    logic             rd_busy_s;
    logic             unused_s;

    function automatic logic [5:0] cfg_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    cfg_addr = 6'h2C;
            2'd1:    cfg_addr = 6'h31;
            2'd2:    cfg_addr = 6'h2D;
            default: cfg_addr = 6'h2C;
        endcase
    endfunction

    function automatic logic [7:0] cfg_value(input logic [1:0] idx);
        case (idx)
            2'd0:    cfg_value = BW_RATE_VAL;
            2'd1:    cfg_value = DATA_FORMAT_VAL;
            2'd2:    cfg_value = POWER_CTL_VAL;
            default: cfg_value = BW_RATE_VAL;
        endcase
    endfunction

    // The sensor's leading status byte carries nothing we need
    assign unused_s = ^spi.spi_buffer[55:48];

    // Tick and read-in-flight qualifiers
    always_comb begin
        tick_s    = 1'b0;
        rd_busy_s = 1'b0;
        if (config_done_r && (cnt_r == CNT_MAX)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
        if ((state_r == RD_ISSUE) || (state_r == RD_RELEASE)) begin
            rd_busy_s = 1'b1;
        end else begin
            rd_busy_s = 1'b0;
        end
    end

    // Sequencer FSM together with the sample divider and tick queue
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            spi_enable_r   <= 1'b0;
            spi_rw_r       <= 1'b0;
            spi_address_r  <= 6'h00;
            spi_value_r    <= 8'h00;
            x_r            <= 16'h0000;
            y_r            <= 16'h0000;
            z_r            <= 16'h0000;
            sample_valid_r <= 1'b0;
            config_done_r  <= 1'b0;
            overrun_r      <= 1'b0;
            pending_r      <= 1'b0;
            cnt_r          <= '0;
            cfg_idx_r      <= 2'd0;
        end else begin
            sample_valid_r <= 1'b0;
            if (!config_done_r || tick_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            // One tick can wait behind a read; a second one is reported and dropped
            if (tick_s && rd_busy_s) begin
                if (pending_r) begin
                    overrun_r <= 1'b1;
                end else begin
                    pending_r <= 1'b1;
                end
            end

            case (state_r)
                IDLE: begin
                    if (run && !spi.spi_sync) begin
                        state_r       <= CFG_ISSUE;
                        cfg_idx_r     <= 2'd0;
                        spi_enable_r  <= 1'b1;
                        spi_rw_r      <= 1'b0;
                        spi_address_r <= cfg_addr(2'd0);
                        spi_value_r   <= cfg_value(2'd0);
                    end
                end
                CFG_ISSUE: begin
                    if (spi.spi_sync) begin
                        state_r      <= CFG_RELEASE;
                        spi_enable_r <= 1'b0;
                    end
                end
                CFG_RELEASE: begin
                    if (!spi.spi_sync) begin
                        cfg_idx_r <= cfg_idx_r + 2'd1;
                        if (!run) begin
                            state_r       <= IDLE;
                            config_done_r <= 1'b0;
                            pending_r     <= 1'b0;
                            cnt_r         <= '0;
                        end else if (cfg_idx_r < 2'd2) begin
                            state_r       <= CFG_ISSUE;
                            spi_enable_r  <= 1'b1;
                            spi_rw_r      <= 1'b0;
                            spi_address_r <= cfg_addr(cfg_idx_r + 2'd1);
                            spi_value_r   <= cfg_value(cfg_idx_r + 2'd1);
                        end else begin
                            state_r       <= WAIT_TICK;
                            config_done_r <= 1'b1;
                        end
                    end
                end
                WAIT_TICK: begin
                    if (!run) begin
                        state_r       <= IDLE;
                        config_done_r <= 1'b0;
                        pending_r     <= 1'b0;
                        cnt_r         <= '0;
                    end else if (tick_s || pending_r) begin
                        state_r       <= RD_ISSUE;
                        spi_enable_r  <= 1'b1;
                        spi_rw_r      <= 1'b1;
                        spi_address_r <= DATA_ADDR;
                        spi_value_r   <= 8'h00;
                        // A fresh tick landing as the queued one is consumed stays queued
                        pending_r     <= tick_s && pending_r;
                    end
                end
                RD_ISSUE: begin
                    if (spi.spi_sync) begin
                        x_r            <= {spi.spi_buffer[39:32], spi.spi_buffer[47:40]};
                        y_r            <= {spi.spi_buffer[23:16], spi.spi_buffer[31:24]};
                        z_r            <= {spi.spi_buffer[7:0],   spi.spi_buffer[15:8]};
                        sample_valid_r <= 1'b1;
                        spi_enable_r   <= 1'b0;
                        state_r        <= RD_RELEASE;
                    end
                end
                RD_RELEASE: begin
                    if (!spi.spi_sync) begin
                        if (!run) begin
                            state_r       <= IDLE;
                            config_done_r <= 1'b0;
                            pending_r     <= 1'b0;
                            cnt_r         <= '0;
                        end else begin
                            state_r <= WAIT_TICK;
                        end
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    spi_enable_r <= 1'b0;
                end
            endcase
        end
    end

    assign spi.spi_enable  = spi_enable_r;
    assign spi.spi_rw      = spi_rw_r;
    assign spi.spi_address = spi_address_r;
    assign spi.spi_value   = spi_value_r;
    assign x               = x_r;
    assign y               = y_r;
    assign z               = z_r;
    assign sample_valid    = sample_valid_r;
    assign config_done     = config_done_r;
    assign overrun         = overrun_r;
endmodule

// File: tb/tb_accel_sequencer.sv
// Randomized scoreboard bench for accel_sequencer with a latency-programmable
// SPI master model; expected samples are queued when the model answers a read.
`timescale 1ns/1ps
module tb_accel_sequencer;
    localparam int DIV = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic        sample_valid;
    logic        config_done;
    logic        overrun;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat = 20;
    bit stuck = 1'b0;
    bit use_fixed = 1'b0;
    int n_rise = 0;
    int n_samples = 0;

    logic [14:0] txn_q[$];
    int          rise_cyc_q[$];
    logic [47:0] exp_q[$];
    logic [14:0] cfg_exp[0:2];

    accel_sequencer_if ifc();

    accel_sequencer #(.SAMPLE_DIV(DIV)) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
        .spi(ifc),
        .x(x),
        .y(y),
        .z(z),
        .sample_valid(sample_valid),
        .config_done(config_done),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SPI master model: answers after 'lat' enabled cycles, holds sync until enable drops
    initial begin
        int          cnt;
        bit          en_prev;
        bit          unstable;
        logic [14:0] cap;
        logic [15:0] ex;
        logic [15:0] ey;
        logic [15:0] ez;
        logic [7:0]  junk;
        cnt = 0;
        en_prev = 1'b0;
        unstable = 1'b0;
        cap = '0;
        ifc.spi_sync = 1'b0;
        ifc.spi_buffer = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                ifc.spi_sync = 1'b0;
                cnt = 0;
                en_prev = 1'b0;
            end else begin
                if (ifc.spi_enable && !en_prev) begin
                    chk("enable_only_after_sync_low", ifc.spi_sync, 1'b0);
                    cap = {ifc.spi_rw, ifc.spi_address, ifc.spi_value};
                    txn_q.push_back(cap);
                    rise_cyc_q.push_back(cyc);
                    n_rise++;
                    unstable = 1'b0;
                end else if (ifc.spi_enable && ({ifc.spi_rw, ifc.spi_address, ifc.spi_value} != cap)) begin
                    unstable = 1'b1;
                end
                if (!ifc.spi_enable && en_prev) chk("fields_stable_while_enabled", unstable, 1'b0);
                en_prev = ifc.spi_enable;
                if (!ifc.spi_enable) begin
                    cnt = 0;
                    if (!stuck) ifc.spi_sync = 1'b0;
                end else if (!ifc.spi_sync) begin
                    cnt++;
                    if (cnt >= lat) begin
                        ifc.spi_sync = 1'b1;
                        if (ifc.spi_rw) begin
                            if (use_fixed) begin
                                ifc.spi_buffer = 56'h00_34_12_78_56_BC_9A;
                                ex = 16'h1234;
                                ey = 16'h5678;
                                ez = 16'h9ABC;
                                use_fixed = 1'b0;
                            end else begin
                                ex = 16'($urandom);
                                ey = 16'($urandom);
                                ez = 16'($urandom);
                                junk = 8'($urandom);
                                ifc.spi_buffer = {junk, ex[7:0], ex[15:8], ey[7:0], ey[15:8],
                                                  ez[7:0], ez[15:8]};
                            end
                            exp_q.push_back({ex, ey, ez});
                        end
                    end
                end
            end
        end
    end

    // Output monitor: every sample_valid pops one expected sample, otherwise outputs hold
    initial begin
        logic [47:0] last;
        logic [47:0] e;
        last = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                last = '0;
                exp_q.delete();
            end else if (sample_valid) begin
                chk("sample_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sample_xyz", {x, y, z}, e);
                    last = e;
                end
                n_samples++;
            end else begin
                chk("xyz_hold", {x, y, z}, last);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        int s0;
        cfg_exp[0] = {1'b0, 6'h2C, 8'h0A};
        cfg_exp[1] = {1'b0, 6'h31, 8'h0B};
        cfg_exp[2] = {1'b0, 6'h2D, 8'h08};
        reset = 1'b1;
        run = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_enable", ifc.spi_enable, 1'b0);
        chk("rst_rw_addr_value", {ifc.spi_rw, ifc.spi_address, ifc.spi_value}, 15'h0);
        chk("rst_xyz", {x, y, z}, 48'h0);
        chk("rst_flags", {sample_valid, config_done, overrun}, 3'b000);

        // Configuration sequence
        reset = 1'b0;
        run = 1'b1;
        for (int i = 0; i < 2000 && !config_done; i++) @(negedge clk);
        chk("config_done", config_done, 1'b1);
        chk("config_write_count", txn_q.size(), 3);
        for (int i = 0; i < 3 && i < txn_q.size(); i++) chk("config_write", txn_q[i], cfg_exp[i]);

        // Periodic reads, first one with the known buffer pattern
        lat = 3;
        use_fixed = 1'b1;
        txn_q.delete();
        rise_cyc_q.delete();
        s0 = n_samples;
        for (int i = 0; i < 2000 && n_samples < s0 + 8; i++) @(negedge clk);
        chk("read_sample_count", n_samples >= s0 + 8, 1'b1);
        for (int i = 0; i < txn_q.size(); i++) chk("read_txn", txn_q[i], {1'b1, 6'h32, 8'h00});
        for (int i = 1; i < rise_cyc_q.size(); i++)
            chk("tick_interval", rise_cyc_q[i] - rise_cyc_q[i-1], DIV);
        chk("no_overrun_fast_spi", overrun, 1'b0);

        // Slow SPI: ticks pile up during reads
        lat = 40;
        s0 = n_samples;
        repeat (400) @(negedge clk);
        chk("overrun_set", overrun, 1'b1);
        chk("reads_continue_slow", n_samples > s0, 1'b1);

        // Drop run while a read is being issued
        lat = 10;
        n0 = n_rise;
        for (int i = 0; i < 500 && n_rise == n0; i++) @(negedge clk);
        chk("read_started", n_rise > n0, 1'b1);
        run = 1'b0;
        n0 = n_rise;
        s0 = n_samples;
        repeat (200) @(negedge clk);
        chk("rundrop_read_completed", n_samples - s0, 1);
        chk("rundrop_no_new_enable", n_rise - n0, 0);
        chk("rundrop_config_cleared", config_done, 1'b0);
        chk("rundrop_enable_low", ifc.spi_enable, 1'b0);
        chk("rundrop_overrun_held", overrun, 1'b1);

        // Reset in the middle of the second configuration write
        lat = 20;
        txn_q.delete();
        n0 = n_rise;
        run = 1'b1;
        for (int i = 0; i < 500 && n_rise < n0 + 2; i++) @(negedge clk);
        chk("second_cfg_started", n_rise >= n0 + 2, 1'b1);
        if (txn_q.size() >= 2) chk("second_cfg_addr", txn_q[1], cfg_exp[1]);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_enable", ifc.spi_enable, 1'b0);
        chk("midrst_rw_addr_value", {ifc.spi_rw, ifc.spi_address, ifc.spi_value}, 15'h0);
        chk("midrst_xyz", {x, y, z}, 48'h0);
        chk("midrst_flags", {sample_valid, config_done, overrun}, 3'b000);
        reset = 1'b0;
        txn_q.delete();
        for (int i = 0; i < 100 && txn_q.size() == 0; i++) @(negedge clk);
        chk("restart_txn_seen", txn_q.size() != 0, 1'b1);
        if (txn_q.size() != 0) chk("restart_first_write", txn_q[0], cfg_exp[0]);

        // Stuck sync: one read, then nothing further
        for (int i = 0; i < 2000 && !config_done; i++) @(negedge clk);
        chk("reconfig_done", config_done, 1'b1);
        stuck = 1'b1;
        n0 = n_rise;
        for (int i = 0; i < 200 && n_rise == n0; i++) @(negedge clk);
        repeat (300) @(negedge clk);
        chk("stuck_single_enable", n_rise - n0, 1);
        chk("stuck_enable_low", ifc.spi_enable, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
